// File: rtl/kmap_lut_seq_pkg.sv
// Shared types and parameter bounds for the kmap_lut_seq truth-table evaluator.
package kmap_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2
  } kmap_state_t;

  localparam int KMAP_N_IN_MIN  = 2;
  localparam int KMAP_N_IN_MAX  = 8;
  localparam int KMAP_N_OUT_MIN = 1;
  localparam int KMAP_N_OUT_MAX = 8;

  // A single channel still needs a 1-bit select so discarded writes stay addressable.
  function automatic int kmap_ch_width(input int n_out);
    return (n_out > 1) ? $clog2(n_out) : 1;
  endfunction

endpackage

// File: rtl/kmap_lut_seq_if.sv
// Handshake bundle between the stimulus source, kmap_lut_seq and the result consumer.
interface kmap_lut_seq_if #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 2
);
  import kmap_pkg::*;

  localparam int D    = 2 ** N_IN;
  localparam int CH_W = kmap_ch_width(N_OUT);

  logic              cfg_valid;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch;
  logic [D-1:0]      cfg_table;
  logic              in_valid;
  logic              in_ready;
  logic [N_IN-1:0]   in_vec;
  logic              sweep_start;
  logic              sweep_busy;
  logic              sweep_done;
  logic              out_valid;
  logic              out_ready;
  logic [N_OUT-1:0]  out_vec;
  logic [N_IN-1:0]   out_idx;

  modport master (
    output cfg_valid, cfg_ch, cfg_table, in_valid, in_vec, sweep_start, out_ready,
    input  cfg_ready, in_ready, sweep_busy, sweep_done, out_valid, out_vec, out_idx
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_table, in_valid, in_vec, sweep_start, out_ready,
    output cfg_ready, in_ready, sweep_busy, sweep_done, out_valid, out_vec, out_idx
  );

endinterface

// File: rtl/kmap_lut_seq_lut_mux_tree.sv
// Combinational 2^N_IN:1 selector returning the truth-table bit addressed by the input vector.
module lut_mux_tree #(
  parameter int N_IN = 4
) (
  input  logic [2**N_IN-1:0] i_table,
  input  logic [N_IN-1:0]    i_sel,
  output logic               o_bit
);

  assign o_bit = i_table[i_sel];

endmodule

// File: rtl/kmap_lut_seq.sv
// Registered, run-time programmable N_IN-input / N_OUT-output Boolean function block
// with valid/ready ports and a built-in full truth-table sweep.
module kmap_lut_seq
  import kmap_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int N_OUT = 2
) (
  input logic          clk,
  input logic          rst_n,
  kmap_lut_seq_if.slave bus
);

  localparam int D    = 2 ** N_IN;
  localparam int CH_W = kmap_ch_width(N_OUT);
  localparam int CW   = N_IN + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(D - 1);

  if ((N_IN < KMAP_N_IN_MIN) || (N_IN > KMAP_N_IN_MAX) ||
      (N_OUT < KMAP_N_OUT_MIN) || (N_OUT > KMAP_N_OUT_MAX)) begin : g_param_err
    $error("kmap_lut_seq: N_IN or N_OUT outside supported range");
  end

  kmap_state_t      r_state;
  kmap_state_t      w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             r_sweep_done;
  logic             w_done_nxt;
  logic [D-1:0]     r_table [N_OUT];
  logic             r_out_valid;
  logic [N_OUT-1:0] r_out_vec;
  logic [N_IN-1:0]  r_out_idx;

  logic             w_out_free;
  logic             w_ext_issue;
  logic             w_swp_issue;
  logic             w_issue;
  logic             w_cfg_acc;
  logic [N_IN-1:0]  w_issue_vec;
  logic [N_OUT-1:0] w_eval;

  assign w_out_free  = !r_out_valid || bus.out_ready;
  assign w_ext_issue = (r_state == IDLE) && bus.in_valid && w_out_free;
  assign w_swp_issue = (r_state == SWEEP) && w_out_free;
  assign w_issue     = w_ext_issue || w_swp_issue;
  assign w_issue_vec = (r_state == SWEEP) ? r_cnt[N_IN-1:0] : bus.in_vec;
  assign w_cfg_acc   = (r_state == IDLE) && bus.cfg_valid;

  // Tables are read before this cycle's write lands, so a colliding issue sees the old table.
  for (genvar k = 0; k < N_OUT; k++) begin : g_ch
    lut_mux_tree #(.N_IN(N_IN)) u_mux (
      .i_table (r_table[k]),
      .i_sel   (w_issue_vec),
      .o_bit   (w_eval[k])
    );
  end

  // Sweep sequencing: next state, counter and completion pulse.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.sweep_start) begin
          w_state_nxt = SWEEP;
          w_cnt_nxt   = {CW{1'b0}};
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SWEEP: begin
        if (w_swp_issue) begin
          w_cnt_nxt = r_cnt + CW'(1);
          if (r_cnt == LAST_IDX) begin
            w_state_nxt = DRAIN;
          end else begin
            w_state_nxt = SWEEP;
          end
        end else begin
          w_state_nxt = SWEEP;
        end
      end
      DRAIN: begin
        if (r_out_valid && bus.out_ready) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = DRAIN;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= {CW{1'b0}};
      r_sweep_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_sweep_done <= w_done_nxt;
    end
  end

  // Truth-table storage; writes to a channel index beyond N_OUT match nothing and vanish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_OUT; k++) begin
        r_table[k] <= {D{1'b0}};
      end
    end else begin
      for (int k = 0; k < N_OUT; k++) begin
        if (w_cfg_acc && (bus.cfg_ch == CH_W'(k))) begin
          r_table[k] <= bus.cfg_table;
        end
      end
    end
  end

  // Single-entry output register; holds its contents while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_vec   <= {N_OUT{1'b0}};
      r_out_idx   <= {N_IN{1'b0}};
    end else if (w_out_free) begin
      r_out_valid <= w_issue;
      if (w_issue) begin
        r_out_vec <= w_eval;
        r_out_idx <= w_issue_vec;
      end
    end
  end

  assign bus.cfg_ready  = (r_state == IDLE);
  assign bus.in_ready   = (r_state == IDLE) && w_out_free;
  assign bus.sweep_busy = (r_state != IDLE);
  assign bus.sweep_done = r_sweep_done;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_vec    = r_out_vec;
  assign bus.out_idx    = r_out_idx;

endmodule

// File: tb/tb_kmap_lut_seq.sv
// Self-checking bench for kmap_lut_seq: a 4-in/2-out and a 6-in/3-out instance
// share one stimulus set, selected through sel, and are checked against a table model.
module tb_kmap_lut_seq;

  logic        clk;
  logic        rst_n;
  logic        sel;
  logic        cfg_valid;
  logic [1:0]  cfg_ch;
  logic [63:0] cfg_table;
  logic        in_valid;
  logic [5:0]  in_vec;
  logic        sweep_start;
  logic        out_ready;

  int checks;
  int failures;
  logic [63:0] mtab [2][3];

  kmap_lut_seq_if #(.N_IN(4), .N_OUT(2)) ifa ();
  kmap_lut_seq_if #(.N_IN(6), .N_OUT(3)) ifb ();

  kmap_lut_seq #(.N_IN(4), .N_OUT(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  kmap_lut_seq #(.N_IN(6), .N_OUT(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  assign ifa.cfg_valid   = cfg_valid & ~sel;
  assign ifa.cfg_ch      = cfg_ch[0];
  assign ifa.cfg_table   = cfg_table[15:0];
  assign ifa.in_valid    = in_valid & ~sel;
  assign ifa.in_vec      = in_vec[3:0];
  assign ifa.sweep_start = sweep_start & ~sel;
  assign ifa.out_ready   = out_ready;
  assign ifb.cfg_valid   = cfg_valid & sel;
  assign ifb.cfg_ch      = cfg_ch;
  assign ifb.cfg_table   = cfg_table;
  assign ifb.in_valid    = in_valid & sel;
  assign ifb.in_vec      = in_vec;
  assign ifb.sweep_start = sweep_start & sel;
  assign ifb.out_ready   = out_ready;

  wire       v_cfg_ready = sel ? ifb.cfg_ready  : ifa.cfg_ready;
  wire       v_in_ready  = sel ? ifb.in_ready   : ifa.in_ready;
  wire       v_busy      = sel ? ifb.sweep_busy : ifa.sweep_busy;
  wire       v_done      = sel ? ifb.sweep_done : ifa.sweep_done;
  wire       v_ovalid    = sel ? ifb.out_valid  : ifa.out_valid;
  wire [2:0] v_ovec      = sel ? ifb.out_vec    : {1'b0, ifa.out_vec};
  wire [5:0] v_oidx      = sel ? ifb.out_idx    : {2'b00, ifa.out_idx};

  typedef struct {
    logic [5:0] vec;
    logic [2:0] exp;
  } ev_t;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic int n_out(input logic s);
    return s ? 3 : 2;
  endfunction

  function automatic int depth(input logic s);
    return s ? 64 : 16;
  endfunction

  function automatic logic [2:0] mdl_eval(input logic s, input int v);
    logic [2:0] r;
    r = 3'b000;
    for (int k = 0; k < n_out(s); k++) r[k] = mtab[s][k][v];
    return r;
  endfunction

  task automatic mdl_clear();
    for (int s = 0; s < 2; s++)
      for (int k = 0; k < 3; k++) mtab[s][k] = 64'd0;
  endtask

  task automatic set_sel(input logic s);
    sel = s;
    #1;
  endtask

  task automatic cfg_write(input int ch, input logic [63:0] t);
    cfg_valid = 1'b1;
    cfg_ch    = 2'(ch);
    cfg_table = t;
    chk("cfg_ready_idle", v_cfg_ready, 1'b1);
    step();
    cfg_valid = 1'b0;
    if (ch < n_out(sel)) mtab[sel][ch] = t;
  endtask

  task automatic eval_one(input string nm, input logic [5:0] v, input logic [2:0] exp);
    in_valid  = 1'b1;
    in_vec    = v;
    out_ready = 1'b1;
    chk("in_ready_idle", v_in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    chk({nm, "_valid"}, v_ovalid, 1'b1);
    chk({nm, "_vec"}, v_ovec, exp);
    chk({nm, "_idx"}, v_oidx, v);
  endtask

  task automatic run_sweep(input bit bp, input bit cfg_hit);
    int d, pos, busy_cnt, done_cnt, last_acc, done_cyc, extra;
    bit stalled;
    logic [5:0] pidx;
    logic [2:0] pvec;
    d = depth(sel); pos = 0; busy_cnt = 0; done_cnt = 0;
    last_acc = -1; done_cyc = -2; extra = 0; stalled = 1'b0;
    pidx = 6'd0; pvec = 3'd0;
    in_valid = 1'b0; cfg_valid = 1'b0; out_ready = 1'b1;
    step();
    sweep_start = 1'b1;
    step();
    sweep_start = 1'b0;
    for (int c = 1; (c < 3000) && (extra < 3); c++) begin
      if (stalled) begin
        chk("stall_valid", v_ovalid, 1'b1);
        chk("stall_idx", v_oidx, pidx);
        chk("stall_vec", v_ovec, pvec);
      end
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (c == 1) begin
        chk("busy_in_ready", v_in_ready, 1'b0);
        chk("busy_cfg_ready", v_cfg_ready, 1'b0);
      end
      if (cfg_hit && (c == 3)) begin
        cfg_valid = 1'b1;
        cfg_ch    = 2'd0;
        cfg_table = ~mtab[sel][0];
        chk("cfg_blocked", v_cfg_ready, 1'b0);
      end else begin
        cfg_valid = 1'b0;
      end
      if (v_busy) busy_cnt++;
      if (v_done) begin
        done_cnt++;
        done_cyc = c;
      end
      if (v_ovalid && out_ready) begin
        chk("sweep_idx", v_oidx, pos);
        chk("sweep_vec", v_ovec, mdl_eval(sel, pos));
        pos++;
        last_acc = c;
      end
      stalled = v_ovalid && !out_ready;
      pidx = v_oidx;
      pvec = v_ovec;
      if (done_cnt > 0) extra++;
      step();
    end
    cfg_valid = 1'b0;
    out_ready = 1'b1;
    chk("sweep_count", pos, d);
    chk("sweep_done_once", done_cnt, 1);
    chk("sweep_done_timing", done_cyc, last_acc + 1);
    if (!bp) chk("sweep_busy_len", busy_cnt, d + 1);
  endtask

  ev_t ev_tab [8];

  initial begin
    logic [2:0] e;
    bit hit7;
    checks = 0; failures = 0;
    rst_n = 1'b0; sel = 1'b0; cfg_valid = 1'b0; cfg_ch = 2'd0; cfg_table = 64'd0;
    in_valid = 1'b0; in_vec = 6'd0; sweep_start = 1'b0; out_ready = 1'b0;
    mdl_clear();
    ev_tab[0] = '{6'h0F, 3'b011};
    ev_tab[1] = '{6'h00, 3'b010};
    ev_tab[2] = '{6'h05, 3'b001};
    ev_tab[3] = '{6'h09, 3'b001};
    ev_tab[4] = '{6'h08, 3'b000};
    ev_tab[5] = '{6'h0C, 3'b000};
    ev_tab[6] = '{6'h0E, 3'b001};
    ev_tab[7] = '{6'h02, 3'b000};

    repeat (3) step();
    rst_n = 1'b1;
    step();
    for (int s = 0; s < 2; s++) begin
      set_sel(1'(s));
      chk("rst_out_valid", v_ovalid, 1'b0);
      chk("rst_out_vec", v_ovec, 3'd0);
      chk("rst_out_idx", v_oidx, 6'd0);
      chk("rst_busy", v_busy, 1'b0);
      chk("rst_done", v_done, 1'b0);
      chk("rst_in_ready", v_in_ready, 1'b1);
      chk("rst_cfg_ready", v_cfg_ready, 1'b1);
    end

    set_sel(1'b0);
    cfg_write(0, 64'hCAF0);
    cfg_write(1, 64'h8001);
    for (int i = 0; i < 8; i++) eval_one("ext_table", ev_tab[i].vec, ev_tab[i].exp);

    // write and evaluate in the same cycle: the result must come from the old table
    e = mdl_eval(sel, 15);
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_table = 64'h1234;
    in_valid = 1'b1; in_vec = 6'h0F; out_ready = 1'b1;
    step();
    cfg_valid = 1'b0; in_valid = 1'b0;
    mtab[0][0] = 64'h1234;
    chk("collide_old_tab", v_ovec, e);
    eval_one("collide_new_tab", 6'h0F, mdl_eval(sel, 15));

    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 2) == 0) cfg_write(int'($urandom_range(0, 1)), {48'd0, 16'($urandom)});
      in_vec = 6'($urandom_range(0, 15));
      eval_one("rand_a", in_vec, mdl_eval(sel, int'(in_vec)));
    end

    cfg_write(0, 64'hA5C3);
    run_sweep(1'b0, 1'b0);
    run_sweep(1'b1, 1'b0);
    run_sweep(1'b0, 1'b1);
    eval_one("tab_kept", 6'h03, mdl_eval(sel, 3));

    // reset while the sweep is at index 7
    run_sweep_start: begin
      step();
      sweep_start = 1'b1;
      step();
      sweep_start = 1'b0;
      hit7 = 1'b0;
      for (int c = 0; (c < 100) && !hit7; c++) begin
        if (v_ovalid && (v_oidx == 6'd7)) hit7 = 1'b1;
        else step();
      end
      chk("reach_idx7", hit7, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", v_ovalid, 1'b0);
      chk("midrst_vec", v_ovec, 3'd0);
      chk("midrst_idx", v_oidx, 6'd0);
      chk("midrst_busy", v_busy, 1'b0);
      mdl_clear();
      for (int c = 0; c < 3; c++) begin
        step();
        chk("midrst_no_done", v_done, 1'b0);
      end
      rst_n = 1'b1;
      step();
      chk("postrst_no_done", v_done, 1'b0);
    end
    cfg_write(0, 64'hA5C3);
    run_sweep(1'b0, 1'b0);

    set_sel(1'b1);
    cfg_write(3, 64'hFFFF_FFFF_FFFF_FFFF);
    eval_one("discard_ch3", 6'h2A, 3'b000);
    for (int k = 0; k < 3; k++) cfg_write(k, {$urandom, $urandom});
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 3) == 0) cfg_write(int'($urandom_range(0, 3)), {$urandom, $urandom});
      in_vec = 6'($urandom_range(0, 63));
      eval_one("rand_b", in_vec, mdl_eval(sel, int'(in_vec)));
    end
    run_sweep(1'b0, 1'b0);
    run_sweep(1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/kmap_lut_seq.md
# kmap_lut_seq

Parametrised, registered successor to the fixed 4-input Karnaugh-map function block. It evaluates `N_OUT` independent, run-time programmable Boolean functions of `N_IN` inputs, each stored as a truth table and selected through a mux tree. Inputs and outputs use valid/ready handshakes. A built-in sweep mode drives all 2^N_IN input combinations through the functions in order, so a full truth-table dump runs in hardware instead of from a bench loop. The block sits between a stimulus source and a result consumer in the combinational-logic lab datapath.

## Interface
- `N_IN`, default 4: number of function inputs (2..8); table depth `D = 2**N_IN`.
- `N_OUT`, default 2: number of output channels (1..8).
- `clk` input, 1 bit: single clock, rising edge.
- `rst_n` input, 1 bit: reset, asynchronous, active-low.
- `cfg_valid` input, 1 bit: table write request.
- `cfg_ready` output, 1 bit: table write accepted this cycle.
- `cfg_ch` input, `$clog2(N_OUT)` bits (min 1): channel whose table is written.
- `cfg_table` input, `D` bits: truth table; bit `i` is the output for input vector `i`.
- `in_valid` input, 1 bit: external evaluation request.
- `in_ready` output, 1 bit: request accepted this cycle.
- `in_vec` input, `N_IN` bits: input vector; MSB is the variable written leftmost in `{a,b,c,d}` order.
- `sweep_start` input, 1 bit: one-cycle pulse that starts a sweep.
- `sweep_busy` output, 1 bit: high while a sweep is running.
- `sweep_done` output, 1 bit: one-cycle pulse when the last sweep result is accepted.
- `out_valid` output, 1 bit: result is held.
- `out_ready` input, 1 bit: consumer accepts the result.
- `out_vec` output, `N_OUT` bits: bit `k` is channel `k`'s function value.
- `out_idx` output, `N_IN` bits: input vector that produced `out_vec`.

## Operation
- Reset values: all tables 0, `out_valid` 0, `out_vec` 0, `out_idx` 0, `sweep_busy` 0, `sweep_done` 0, state IDLE, sweep counter 0.
- FSM `IDLE -> SWEEP -> DRAIN -> IDLE`.
  - IDLE: `sweep_start` moves to SWEEP and clears the counter. The external port is open.
  - SWEEP: the counter value is issued as the input vector whenever the output stage can accept it; the counter increments on each issue. Issuing `D-1` moves to DRAIN.
  - DRAIN: waits for the final result to be accepted, pulses `sweep_done`, then returns to IDLE.
- `sweep_start` outside IDLE is ignored.
- `sweep_busy` = (state != IDLE).
- `cfg_ready` = (state == IDLE). An accepted write replaces the table of `cfg_ch` from the next cycle. A `cfg_ch >= N_OUT` write is accepted and discarded.
- `in_ready` = (state == IDLE) && (!out_valid || out_ready).
- Simultaneous events:
  - `sweep_start` and `in_valid` in IDLE: the external request is accepted in that cycle; the sweep begins next cycle.
  - `cfg_valid` and an input issue in the same cycle: the evaluation uses the old table.
- Output stage is a single register. It loads when `!out_valid || out_ready` and an issue occurs. It holds `out_vec`/`out_idx` stable while `out_valid && !out_ready`.
- Counter is `N_IN+1` bits internally, so there is no wrap ambiguity at `D-1`.

## Timing
- Latency: an issue at cycle t gives `out_valid` at t+1.
- Throughput: one result per cycle with `out_ready` held high.
- A sweep with `out_ready` held high takes `D` issue cycles. `sweep_done` pulses in the cycle after the last acceptance, so `sweep_busy` is high for `D+1` cycles after the start pulse.
- Deasserting `out_ready` stalls the sweep with no lost or duplicated index.
- Reset mid-sweep: all state clears asynchronously and no `sweep_done` is emitted.

## Structure
- Package `kmap_pkg` holds:
  - the state enum `kmap_state_t` (IDLE/SWEEP/DRAIN);
  - constants for the min/max legal `N_IN` and `N_OUT`.
- Sub-module `lut_mux_tree` (parameter `N_IN`) is a purely combinational 2^N:1 mux selecting a table bit by input vector. It is instantiated `N_OUT` times through a generate loop.
- Elaboration assertion: `N_IN` and `N_OUT` are within the package bounds.

## Test plan
- Reset, then hold: all outputs 0, `in_ready`=1, `cfg_ready`=1.
- External eval:
  - stimulus: load ch0=`16'hCAF0`, ch1=`16'h8001`; drive `in_vec`=4'hF then 4'h0 with `out_ready`=1;
  - required response: `out_vec`=2'b11 then 2'b10, each 1 cycle after the request.
- Full sweep, N_IN=4:
  - stimulus: ch0=`16'hA5C3`; pulse `sweep_start`;
  - required response: `out_idx` runs 0..15 and `out_vec[0]` follows bits 0..15 of `16'hA5C3`; `sweep_done` pulses once; `sweep_busy` is high for 17 cycles.
- Backpressure: toggle `out_ready` randomly during a sweep -> every index 0..15 appears exactly once in order; outputs stay stable while stalled.
- Config collisions:
  - `cfg_valid` during a sweep -> `cfg_ready`=0 and the table is unchanged.
  - `cfg_valid` together with `in_valid` in IDLE -> that evaluation uses the old table.
- Reset mid-sweep: assert `rst_n`=0 at index 7 -> outputs clear immediately and no `sweep_done`; a new sweep then restarts at index 0. Rerun the sweep scenario at N_IN=6, N_OUT=3.
